frame_stats_monitor: RTL

//  Parametrised per-frame statistics engine on the pixel-clock side of the camera path.

---
 rtl/frame_stats_monitor.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_stats_monitor.sv
// frame_stats_monitor
// Per-frame statistics engine on the pixel-clock side of the camera path.
// Watches fv/lv/pd after byte-to-pixel conversion, measures each frame
// (line count, longest/shortest line, pixel checksum) and publishes a
// snapshot of every completed frame through a small read window.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_SYNC  | after reset/clear; waits for fv low so partial frames are dropped
// S_IDLE  | between frames; waits for fv rising edge
// S_FRAME | frame in progress; running stats accumulate
module frame_stats_monitor #(
    parameter int PIXEL_W = 10,
    parameter int CNT_W   = 16,
    parameter int FRAME_W = 8,
    parameter int SUM_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fv,
    input  logic               lv,
    input  logic [PIXEL_W-1:0] pd,
    input  logic               clear,
    input  logic [2:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               snap_valid,
    output logic [FRAME_W-1:0] frame_count,
    output logic               in_frame
);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_IDLE  = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]      BLOCK_ID = 32'hF5A0_0001;

    state_t             r_state;
    logic               r_fv_q;
    logic               r_lv_q;

    logic [CNT_W-1:0]   r_cur_pix;
    logic [CNT_W-1:0]   r_line_cnt;
    logic [CNT_W-1:0]   r_max;
    logic [CNT_W-1:0]   r_min;
    logic [SUM_W-1:0]   r_sum;

    logic [CNT_W-1:0]   r_snap_lines;
    logic [CNT_W-1:0]   r_snap_max;
    logic [CNT_W-1:0]   r_snap_min;
    logic [SUM_W-1:0]   r_snap_sum;
    logic [FRAME_W-1:0] r_frame_count;
    logic               r_snap_valid;

    logic               r_ovf;
    logic               r_err_lv_no_fv;
    logic               r_err_lv_at_sof;
    logic [31:0]        r_rd_data;

    logic               w_rise_f;
    logic               w_fall_f;
    logic               w_fall_l;
    logic               w_in_frame;
    logic               w_pix;
    logic               w_line_end;
    logic               w_pix_sat;
    logic               w_line_sat;
    logic [SUM_W-1:0]   w_pd_ext;
    logic [CNT_W-1:0]   w_cur_pix_nxt;
    logic [CNT_W-1:0]   w_line_cnt_nxt;
    logic [CNT_W-1:0]   w_max_nxt;
    logic [CNT_W-1:0]   w_min_nxt;
    logic [SUM_W-1:0]   w_sum_nxt;
    logic [31:0]        w_rd_mux;

    assign w_rise_f   = fv & ~r_fv_q;
    assign w_fall_f   = ~fv & r_fv_q;
    assign w_fall_l   = ~lv & r_lv_q;
    assign w_in_frame = (r_state == S_FRAME);

    // A pixel is never qualified in the fall_f cycle (fv is low), so pixel
    // counting and line closing are mutually exclusive within one cycle.
    // A line still open when fv drops is closed as if lv had fallen.
    assign w_pix      = w_in_frame & fv & lv;
    assign w_line_end = w_in_frame & (w_fall_l | (w_fall_f & r_lv_q));
    assign w_pix_sat  = w_pix & (r_cur_pix == CNT_MAX);
    assign w_line_sat = w_line_end & (r_line_cnt == CNT_MAX);
    assign w_pd_ext   = SUM_W'(pd);

    // Next values of the running stats; the snapshot latches these so a
    // line closing on the frame-end edge is already included.
    always_comb begin
        w_cur_pix_nxt  = r_cur_pix;
        w_line_cnt_nxt = r_line_cnt;
        w_max_nxt      = r_max;
        w_min_nxt      = r_min;
        w_sum_nxt      = r_sum;
        if (w_pix) begin
            w_sum_nxt = r_sum + w_pd_ext;
            if (!w_pix_sat) begin
                w_cur_pix_nxt = r_cur_pix + 1'b1;
            end
        end
        if (w_line_end) begin
            w_cur_pix_nxt = '0;
            if (!w_line_sat) begin
                w_line_cnt_nxt = r_line_cnt + 1'b1;
            end
            if (r_cur_pix > r_max) begin
                w_max_nxt = r_cur_pix;
            end
            // line_cnt never wraps, so zero reliably marks the first line
            if ((r_line_cnt == '0) || (r_cur_pix < r_min)) begin
                w_min_nxt = r_cur_pix;
            end
        end
    end

    // Delayed fv/lv for edge detection; free-running, unaffected by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fv_q <= 1'b0;
            r_lv_q <= 1'b0;
        end else begin
            r_fv_q <= fv;
            r_lv_q <= lv;
        end
    end

    // Frame FSM with running stats, snapshot capture and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_SYNC;
            r_cur_pix     <= '0;
            r_line_cnt    <= '0;
            r_max         <= '0;
            r_min         <= '0;
            r_sum         <= '0;
            r_snap_lines  <= '0;
            r_snap_max    <= '0;
            r_snap_min    <= '0;
            r_snap_sum    <= '0;
            r_frame_count <= '0;
            r_snap_valid  <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            if (clear) begin
                // clear outranks a coincident fall_f: the frame is dropped
                r_state       <= S_SYNC;
                r_cur_pix     <= '0;
                r_line_cnt    <= '0;
                r_max         <= '0;
                r_min         <= '0;
                r_sum         <= '0;
                r_snap_lines  <= '0;
                r_snap_max    <= '0;
                r_snap_min    <= '0;
                r_snap_sum    <= '0;
                r_frame_count <= '0;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        if (!fv) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (w_rise_f) begin
                            r_state    <= S_FRAME;
                            r_cur_pix  <= '0;
                            r_line_cnt <= '0;
                            r_max      <= '0;
                            r_min      <= '0;
                            r_sum      <= '0;
                        end
                    end
                    S_FRAME: begin
                        r_cur_pix  <= w_cur_pix_nxt;
                        r_line_cnt <= w_line_cnt_nxt;
                        r_max      <= w_max_nxt;
                        r_min      <= w_min_nxt;
                        r_sum      <= w_sum_nxt;
                        if (w_fall_f) begin
                            r_state       <= S_IDLE;
                            r_snap_lines  <= w_line_cnt_nxt;
                            r_snap_max    <= w_max_nxt;
                            r_snap_min    <= w_min_nxt;
                            r_snap_sum    <= w_sum_nxt;
                            r_frame_count <= r_frame_count + 1'b1;
                            r_snap_valid  <= 1'b1;
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

    // Sticky protocol errors and saturation flag.
    // The start-of-frame check only applies to a real frame start seen from
    // S_IDLE, so releasing reset in the middle of a frame does not flag it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf           <= 1'b0;
            r_err_lv_no_fv  <= 1'b0;
            r_err_lv_at_sof <= 1'b0;
        end else if (clear) begin
            r_ovf           <= 1'b0;
            r_err_lv_no_fv  <= 1'b0;
            r_err_lv_at_sof <= 1'b0;
        end else begin
            if (lv && !fv) begin
                r_err_lv_no_fv <= 1'b1;
            end
            if (w_rise_f && lv && (r_state == S_IDLE)) begin
                r_err_lv_at_sof <= 1'b1;
            end
            if (w_pix_sat || w_line_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Register window decode.
    always_comb begin
        w_rd_mux = 32'h0;
        case (rd_addr)
            3'd0: w_rd_mux = 32'(r_frame_count);
            3'd1: w_rd_mux = 32'(r_snap_lines);
            3'd2: w_rd_mux = 32'(r_snap_max);
            3'd3: w_rd_mux = 32'(r_snap_min);
            3'd4: w_rd_mux = 32'(r_snap_sum);
            3'd5: w_rd_mux = {26'b0, r_ovf, r_err_lv_at_sof, r_err_lv_no_fv,
                              w_in_frame, r_state};
            3'd6: w_rd_mux = BLOCK_ID;
            default: w_rd_mux = 32'h0;
        endcase
    end

    // Read data registered: reflects the address of the previous cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= 32'h0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data     = r_rd_data;
    assign snap_valid  = r_snap_valid;
    assign frame_count = r_frame_count;
    assign in_frame    = w_in_frame;

endmodule
